// File: rtl/cache_mem_arbiter.sv
// Shares the single cacheline-adaptor port between the I-cache and D-cache.
// One requester is served at a time; ties go to the side not granted last.
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // Adaptor side
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  // Debug view of the arbiter state: 0 idle, 1 serving I, 2 serving D
  output logic [1:0]        o_dbg_state
);

  // Handshake: a cache raises its request and holds it, with stable address
  // and data, until its resp pulses; it drops the request in the following
  // cycle. The adaptor sees a request level for the whole serve and ends it
  // with a one-cycle pmem_resp.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last_grant_d;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // I wins when alone, or on a tie when D was granted last.
  assign w_grant_i = w_i_req & (~w_d_req | r_last_grant_d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_last_grant_d <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_i) begin
            r_state        <= ST_SERVE_I;
            r_last_grant_d <= 1'b0;
          end else if (w_d_req) begin
            r_state        <= ST_SERVE_D;
            r_last_grant_d <= 1'b1;
          end
        end
        ST_SERVE_I: begin
          if (pmem_resp) r_state <= ST_IDLE;
        end
        ST_SERVE_D: begin
          if (pmem_resp) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Port muxing is decoded from the registered state; only resp follows
  // pmem_resp combinationally so the cache sees completion in the same cycle.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (r_state)
      ST_SERVE_I: begin
        pmem_read = 1'b1;
        pmem_addr = i_addr;
        i_resp    = pmem_resp;
      end
      ST_SERVE_D: begin
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
        pmem_write = d_write;
        pmem_read  = ~d_write;
        d_resp     = pmem_resp;
      end
      default: begin
      end
    endcase
  end

  assign i_rdata     = pmem_rdata;
  assign d_rdata     = pmem_rdata;
  assign o_dbg_state = r_state;

`ifndef SYNTHESIS
  // Write wins if both D requests are raised, but that is a cache bug.
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(d_read && d_write))
    else $error("cache_mem_arbiter: d_read and d_write both high");

  a_i_req_held: assert property (@(posedge clk) disable iff (!rst)
    (r_state == ST_SERVE_I) |-> w_i_req)
    else $error("cache_mem_arbiter: i_read dropped while being served");

  a_d_req_held: assert property (@(posedge clk) disable iff (!rst)
    (r_state == ST_SERVE_D) |-> w_d_req)
    else $error("cache_mem_arbiter: D request dropped while being served");
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset, single-side traffic,
// round-robin ties, contention while busy and reset during a serve.
module tb_cache_mem_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_I    = 2'd1;
  localparam logic [1:0] S_D    = 2'd2;

  localparam logic [LINE_W-1:0] PAT_A = {4{64'hDEAD_BEEF_0123_4567}};
  localparam logic [LINE_W-1:0] PAT_B = {8{32'hB0B0_C1C1}};

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [1:0]        dbg_state;

  int n_total;
  int n_bad;

  cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp),
    .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic exp_rd, input logic exp_wr,
                          input logic [ADDR_W-1:0] exp_addr, input logic [1:0] exp_st);
    check({tag, "_rd"},    LINE_W'(pmem_read),  LINE_W'(exp_rd));
    check({tag, "_wr"},    LINE_W'(pmem_write), LINE_W'(exp_wr));
    check({tag, "_addr"},  LINE_W'(pmem_addr),  LINE_W'(exp_addr));
    check({tag, "_state"}, LINE_W'(dbg_state),  LINE_W'(exp_st));
  endtask

  task automatic chk_resp(input string tag, input logic exp_i, input logic exp_d);
    check({tag, "_iresp"}, LINE_W'(i_resp), LINE_W'(exp_i));
    check({tag, "_dresp"}, LINE_W'(d_resp), LINE_W'(exp_d));
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge and
  // outputs are sampled 1 unit later, well before the falling edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive_idle;
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    drive_idle();

    // Reset held two cycles with an I request pending
    rst    = 1'b0;
    i_read = 1'b1;
    i_addr = 32'h0000_0100;
    tick(); tick(); settle();
    chk_port("rst", 1'b0, 1'b0, 32'h0, S_IDLE);
    check("rst_wdata", pmem_wdata, '0);
    chk_resp("rst", 1'b0, 1'b0);
    rst = 1'b1;
    settle();
    chk_port("rel_idle", 1'b0, 1'b0, 32'h0, S_IDLE);
    tick(); settle();
    chk_port("rel_grant", 1'b1, 1'b0, 32'h0000_0100, S_I);
    pmem_resp = 1'b1;
    settle();
    chk_resp("rel_resp", 1'b1, 1'b0);
    tick();
    drive_idle();
    settle();
    chk_port("rel_done", 1'b0, 1'b0, 32'h0, S_IDLE);

    // I-only read, adaptor answers in the fourth serve cycle
    i_read = 1'b1;
    i_addr = 32'h0000_1000;
    settle();
    chk_port("ird_idle", 1'b0, 1'b0, 32'h0, S_IDLE);
    tick(); settle();
    chk_port("ird_grant", 1'b1, 1'b0, 32'h0000_1000, S_I);
    for (int k = 0; k < 3; k++) begin
      chk_resp("ird_wait", 1'b0, 1'b0);
      tick(); settle();
    end
    pmem_rdata = PAT_A;
    pmem_resp  = 1'b1;
    settle();
    chk_resp("ird_resp", 1'b1, 1'b0);
    check("ird_irdata", i_rdata, PAT_A);
    check("ird_drdata", d_rdata, PAT_A);
    tick();
    drive_idle();
    settle();
    chk_resp("ird_after", 1'b0, 1'b0);
    chk_port("ird_after", 1'b0, 1'b0, 32'h0, S_IDLE);

    // D writeback
    d_write = 1'b1;
    d_addr  = 32'h0000_2020;
    d_wdata = PAT_B;
    tick(); settle();
    chk_port("dwb_grant", 1'b0, 1'b1, 32'h0000_2020, S_D);
    check("dwb_wdata", pmem_wdata, PAT_B);
    chk_resp("dwb_wait", 1'b0, 1'b0);
    pmem_resp = 1'b1;
    settle();
    chk_resp("dwb_resp", 1'b0, 1'b1);
    tick();
    drive_idle();
    settle();
    chk_resp("dwb_after", 1'b0, 1'b0);
    chk_port("dwb_after", 1'b0, 1'b0, 32'h0, S_IDLE);
    check("dwb_after_wdata", pmem_wdata, '0);

    // Simultaneous requests from reset: I, then D, then I again
    rst = 1'b0;
    tick();
    rst    = 1'b1;
    i_read = 1'b1;
    i_addr = 32'h0000_3000;
    d_read = 1'b1;
    d_addr = 32'h0000_4040;
    settle();
    chk_port("tie_idle0", 1'b0, 1'b0, 32'h0, S_IDLE);
    tick(); settle();
    chk_port("tie_g1", 1'b1, 1'b0, 32'h0000_3000, S_I);
    pmem_resp = 1'b1;
    settle();
    chk_resp("tie_r1", 1'b1, 1'b0);
    tick();
    i_read    = 1'b0;
    pmem_resp = 1'b0;
    settle();
    chk_port("tie_idle1", 1'b0, 1'b0, 32'h0, S_IDLE);
    tick(); settle();
    chk_port("tie_g2", 1'b1, 1'b0, 32'h0000_4040, S_D);
    pmem_resp = 1'b1;
    settle();
    chk_resp("tie_r2", 1'b0, 1'b1);
    tick();
    d_read    = 1'b0;
    i_read    = 1'b1;
    pmem_resp = 1'b0;
    settle();
    chk_port("tie_idle2", 1'b0, 1'b0, 32'h0, S_IDLE);
    tick(); settle();
    chk_port("tie_g3", 1'b1, 1'b0, 32'h0000_3000, S_I);
    pmem_resp = 1'b1;
    settle();
    chk_resp("tie_r3", 1'b1, 1'b0);
    tick();
    drive_idle();
    settle();
    chk_port("tie_idle3", 1'b0, 1'b0, 32'h0, S_IDLE);

    // Tie after an I grant goes to D
    i_read = 1'b1;
    i_addr = 32'h0000_3100;
    d_read = 1'b1;
    d_addr = 32'h0000_4100;
    tick(); settle();
    chk_port("rr_d_first", 1'b1, 1'b0, 32'h0000_4100, S_D);
    pmem_resp = 1'b1;
    settle();
    chk_resp("rr_d_resp", 1'b0, 1'b1);
    tick();
    d_read    = 1'b0;
    pmem_resp = 1'b0;
    tick(); settle();
    chk_port("rr_i_next", 1'b1, 1'b0, 32'h0000_3100, S_I);
    pmem_resp = 1'b1;
    settle();
    chk_resp("rr_i_resp", 1'b1, 1'b0);
    tick();
    drive_idle();

    // D request arrives while I is being served
    i_read = 1'b1;
    i_addr = 32'h0000_5000;
    tick(); settle();
    chk_port("busy_i", 1'b1, 1'b0, 32'h0000_5000, S_I);
    d_read = 1'b1;
    d_addr = 32'h0000_6000;
    tick(); settle();
    chk_port("busy_i_hold", 1'b1, 1'b0, 32'h0000_5000, S_I);
    chk_resp("busy_wait", 1'b0, 1'b0);
    pmem_resp = 1'b1;
    settle();
    chk_resp("busy_iresp", 1'b1, 1'b0);
    tick();
    i_read    = 1'b0;
    pmem_resp = 1'b0;
    settle();
    chk_port("busy_idle", 1'b0, 1'b0, 32'h0, S_IDLE);
    chk_resp("busy_idle", 1'b0, 1'b0);
    tick(); settle();
    chk_port("busy_d", 1'b1, 1'b0, 32'h0000_6000, S_D);
    pmem_resp = 1'b1;
    settle();
    chk_resp("busy_dresp", 1'b0, 1'b1);
    tick();
    drive_idle();

    // Reset in the middle of a D serve, then a normal I read
    d_read = 1'b1;
    d_addr = 32'h0000_7000;
    tick(); settle();
    chk_port("mid_d", 1'b1, 1'b0, 32'h0000_7000, S_D);
    rst = 1'b0;
    settle();
    chk_resp("mid_rst", 1'b0, 1'b0);
    tick();
    rst    = 1'b1;
    d_read = 1'b0;
    settle();
    chk_port("mid_after", 1'b0, 1'b0, 32'h0, S_IDLE);
    chk_resp("mid_after", 1'b0, 1'b0);
    i_read = 1'b1;
    i_addr = 32'h0000_8000;
    tick(); settle();
    chk_port("mid_i", 1'b1, 1'b0, 32'h0000_8000, S_I);
    pmem_rdata = PAT_B;
    pmem_resp  = 1'b1;
    settle();
    chk_resp("mid_iresp", 1'b1, 1'b0);
    check("mid_irdata", i_rdata, PAT_B);
    tick();
    drive_idle();
    settle();
    chk_port("mid_done", 1'b0, 1'b0, 32'h0, S_IDLE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
